// File: rtl/stroke_if.sv
// Flywheel sensor / stroke event bundle.
// master: detector side (takes sensor, drives phase/interval/start pulses); slave: consumer side.
interface stroke_if;
    logic        sensor;
    logic        start_drive;
    logic        start_recovery;
    logic [1:0]  phase;
    logic [31:0] interval;
    logic        interval_valid;

    modport master (
        input  sensor,
        output start_drive,
        output start_recovery,
        output phase,
        output interval,
        output interval_valid
    );

    modport slave (
        output sensor,
        input  start_drive,
        input  start_recovery,
        input  phase,
        input  interval,
        input  interval_valid
    );
endinterface

// File: rtl/stroke_detector.sv
// Rowing stroke detector: debounces the flywheel magnet pulse, times tick intervals
// and tracks IDLE/RECOVERY/DRIVE. Ports: clk, reset (sync, active-low), bus (stroke_if.master).
module stroke_detector #(
    parameter int          DEBOUNCE  = 4,
    parameter int          MIN_TICKS = 3,
    parameter logic [31:0] STALL     = 32'd50_000_000
) (
    input  logic      clk,
    input  logic      reset,
    stroke_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RECOVERY = 2'b01,
        DRIVE    = 2'b10
    } phase_t;

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(MIN_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [SW-1:0] ST_MAX  = SW'(MIN_TICKS);

    logic          sync1;
    logic          sync2;
    logic          db;
    logic [DW-1:0] db_cnt;
    logic          tick;
    logic [31:0]   count;
    logic [31:0]   prev;
    logic          primed;
    logic [SW-1:0] accel;
    logic [SW-1:0] decel;
    logic [SW-1:0] accel_n;
    logic [SW-1:0] decel_n;
    phase_t        state;
    logic          sd_q;
    logic          sr_q;
    logic [31:0]   ival_q;
    logic          iv_q;

    // Streaks after comparing the interval ending now with the previous one.
    // Equal intervals leave both streaks untouched.
    always_comb begin
        accel_n = accel;
        decel_n = decel;
        if (count < prev) begin
            accel_n = (accel == ST_MAX) ? accel : accel + 1'b1;
            decel_n = '0;
        end else if (count > prev) begin
            decel_n = (decel == ST_MAX) ? decel : decel + 1'b1;
            accel_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db     <= 1'b0;
            db_cnt <= '0;
            tick   <= 1'b0;
            count  <= '0;
            prev   <= '0;
            primed <= 1'b0;
            accel  <= '0;
            decel  <= '0;
            state  <= IDLE;
            sd_q   <= 1'b0;
            sr_q   <= 1'b0;
            ival_q <= '0;
            iv_q   <= 1'b0;
        end else begin
            sync1 <= bus.sensor;
            sync2 <= sync1;

            // db follows sync2 only after DEBOUNCE consecutive disagreeing cycles.
            tick <= 1'b0;
            if (sync2 != db) begin
                if (db_cnt == DB_LAST) begin
                    db     <= sync2;
                    db_cnt <= '0;
                    tick   <= sync2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            sd_q <= 1'b0;
            sr_q <= 1'b0;
            iv_q <= 1'b0;

            // A tick takes priority over the stall check in the same cycle.
            if (tick) begin
                count  <= 32'd1;
                prev   <= count;
                primed <= 1'b1;
                // The priming tick only seeds prev with the time since idle.
                if (primed) begin
                    ival_q <= count;
                    iv_q   <= 1'b1;
                    if (state != DRIVE && accel_n == ST_MAX) begin
                        state <= DRIVE;
                        sd_q  <= 1'b1;
                        accel <= '0;
                        decel <= '0;
                    end else if (state == DRIVE && decel_n == ST_MAX) begin
                        state <= RECOVERY;
                        sr_q  <= 1'b1;
                        accel <= '0;
                        decel <= '0;
                    end else begin
                        accel <= accel_n;
                        decel <= decel_n;
                    end
                end
            end else begin
                if (count != 32'hFFFF_FFFF) begin
                    count <= count + 32'd1;
                end
                if (count == STALL) begin
                    state  <= IDLE;
                    primed <= 1'b0;
                    prev   <= '0;
                    accel  <= '0;
                    decel  <= '0;
                end
            end
        end
    end

    assign bus.phase          = state;
    assign bus.start_drive    = sd_q;
    assign bus.start_recovery = sr_q;
    assign bus.interval       = ival_q;
    assign bus.interval_valid = iv_q;

endmodule

// File: tb/tb_stroke_detector.sv
// Directed bench for stroke_detector (DEBOUNCE=2, MIN_TICKS=3, STALL=1000).
// Sensor rises are spaced by exact cycle counts; events are logged and checked per scenario.
module tb_stroke_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stroke_if bus ();

    stroke_detector #(
        .DEBOUNCE (2),
        .MIN_TICKS(3),
        .STALL    (32'd1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int iv_val[$];
    int iv_cyc[$];
    int sd_q[$];
    int sr_q[$];
    int rise_q[$];
    int viol = 0;
    logic prev_sd = 1'b0;
    logic prev_sr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.interval_valid) begin
            iv_val.push_back(int'(bus.interval));
            iv_cyc.push_back(cyc);
        end
        if (bus.start_drive) sd_q.push_back(cyc);
        if (bus.start_recovery) sr_q.push_back(cyc);
        if ((bus.start_drive && bus.start_recovery) ||
            (bus.start_drive && prev_sd) ||
            (bus.start_recovery && prev_sr))
            viol <= viol + 1;
        prev_sd <= bus.start_drive;
        prev_sr <= bus.start_recovery;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iv_val.delete();
        iv_cyc.delete();
        sd_q.delete();
        sr_q.delete();
        rise_q.delete();
    endtask

    task automatic do_reset();
        bus.sensor = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Sensor high for 10 cycles; next rise exactly p cycles after this one.
    task automatic period(input int p);
        rise_q.push_back(cyc);
        bus.sensor = 1'b1;
        repeat (10) step();
        bus.sensor = 1'b0;
        repeat (p - 10) step();
    endtask

    // Same as period, plus a single-cycle high glitch in the low phase.
    task automatic period_glitch(input int p);
        rise_q.push_back(cyc);
        bus.sensor = 1'b1;
        repeat (10) step();
        bus.sensor = 1'b0;
        repeat (90) step();
        bus.sensor = 1'b1;
        step();
        bus.sensor = 1'b0;
        repeat (p - 101) step();
    endtask

    task automatic test_reset();
        bus.sensor = 1'b0;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (bus.phase !== 2'b00) begin
            errors++;
            $display("FAIL reset_phase: got %b required 00", bus.phase);
        end
        checks++;
        if (bus.start_drive !== 1'b0 || bus.start_recovery !== 1'b0) begin
            errors++;
            $display("FAIL reset_starts: got %b%b required 00",
                     bus.start_drive, bus.start_recovery);
        end
        checks++;
        if (bus.interval !== 32'd0 || bus.interval_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_interval: got %0d/%b required 0/0",
                     bus.interval, bus.interval_valid);
        end
        reset = 1'b1;
    endtask

    task automatic test_drive_recovery();
        int exp[7] = '{300, 250, 200, 220, 260, 300, 300};
        do_reset();
        clear_logs();
        repeat (400) step();
        period(300);
        period(250);
        period(200);
        period(220);
        period(260);
        period(300);
        period(300);
        period(20);
        checks++;
        if (iv_val.size() != 7) begin
            errors++;
            $display("FAIL dr_iv_count: got %0d required 7", iv_val.size());
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= iv_val.size() || iv_val[i] != exp[i]) begin
                errors++;
                $display("FAIL dr_interval[%0d]: got %0d required %0d",
                         i, (i < iv_val.size()) ? iv_val[i] : -1, exp[i]);
            end
        end
        checks++;
        if (iv_cyc.size() == 0 || iv_cyc[0] != rise_q[1] + 5) begin
            errors++;
            $display("FAIL dr_latency: got %0d required %0d",
                     (iv_cyc.size() > 0) ? iv_cyc[0] : -1, rise_q[1] + 5);
        end
        checks++;
        if (sd_q.size() != 1 || sd_q[0] != rise_q[3] + 5) begin
            errors++;
            $display("FAIL dr_start_drive: got %0d pulses first at %0d required 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, rise_q[3] + 5);
        end
        checks++;
        if (sr_q.size() != 1 || sr_q[0] != rise_q[6] + 5) begin
            errors++;
            $display("FAIL dr_start_recovery: got %0d pulses first at %0d required 1 at %0d",
                     sr_q.size(), (sr_q.size() > 0) ? sr_q[0] : -1, rise_q[6] + 5);
        end
        checks++;
        if (bus.phase !== 2'b01) begin
            errors++;
            $display("FAIL dr_phase: got %b required 01", bus.phase);
        end
    endtask

    task automatic test_glitch();
        int exp[3] = '{350, 330, 310};
        do_reset();
        clear_logs();
        repeat (400) step();
        period_glitch(350);
        period_glitch(330);
        period_glitch(310);
        period(20);
        checks++;
        if (iv_val.size() != 3) begin
            errors++;
            $display("FAIL gl_iv_count: got %0d required 3", iv_val.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= iv_val.size() || iv_val[i] != exp[i]) begin
                errors++;
                $display("FAIL gl_interval[%0d]: got %0d required %0d",
                         i, (i < iv_val.size()) ? iv_val[i] : -1, exp[i]);
            end
        end
        checks++;
        if (sd_q.size() != 1 || sd_q[0] != rise_q[3] + 5) begin
            errors++;
            $display("FAIL gl_start_drive: got %0d pulses first at %0d required 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, rise_q[3] + 5);
        end
    endtask

    task automatic test_equal_tick_stall();
        int exp[5] = '{300, 300, 250, 200, 1000};
        int r5;
        int n;
        do_reset();
        clear_logs();
        repeat (400) step();
        period(300);
        period(300);
        period(250);
        period(200);
        period(1000);
        r5 = cyc;
        bus.sensor = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.interval_valid !== 1'b1 || bus.interval !== 32'd1000) begin
            errors++;
            $display("FAIL tick_at_stall_iv: got %b/%0d required 1/1000",
                     bus.interval_valid, bus.interval);
        end
        checks++;
        if (bus.phase !== 2'b10) begin
            errors++;
            $display("FAIL tick_at_stall_phase: got %b required 10", bus.phase);
        end
        repeat (5) step();
        bus.sensor = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= iv_val.size() || iv_val[i] != exp[i]) begin
                errors++;
                $display("FAIL eq_interval[%0d]: got %0d required %0d",
                         i, (i < iv_val.size()) ? iv_val[i] : -1, exp[i]);
            end
        end
        checks++;
        if (sd_q.size() != 1 || sd_q[0] != rise_q[4] + 5) begin
            errors++;
            $display("FAIL eq_start_drive: got %0d pulses first at %0d required 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, rise_q[4] + 5);
        end
        repeat (r5 + 1004 - cyc) step();
        checks++;
        if (bus.phase !== 2'b10) begin
            errors++;
            $display("FAIL pre_stall_phase: got %b required 10", bus.phase);
        end
        step();
        checks++;
        if (bus.phase !== 2'b00) begin
            errors++;
            $display("FAIL stall_phase: got %b required 00", bus.phase);
        end
        checks++;
        if (sd_q.size() != 1 || sr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_no_pulse: got drive=%0d recovery=%0d required 1/0",
                     sd_q.size(), sr_q.size());
        end
        n = iv_val.size();
        period(300);
        period(20);
        checks++;
        if (iv_val.size() != n + 1 || iv_val[n] != 300) begin
            errors++;
            $display("FAIL post_stall_priming: got %0d new intervals required 1 of 300",
                     iv_val.size() - n);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d required 0", viol);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_logs();
        repeat (400) step();
        period(300);
        period(250);
        bus.sensor = 1'b1;
        repeat (10) step();
        bus.sensor = 1'b0;
        repeat (20) step();
        checks++;
        if (iv_val.size() != 2 || bus.interval !== 32'd250) begin
            errors++;
            $display("FAIL mid_pre_reset: got %0d intervals last %0d required 2 last 250",
                     iv_val.size(), bus.interval);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.phase !== 2'b00 || bus.interval !== 32'd0 ||
            bus.interval_valid !== 1'b0 || bus.start_drive !== 1'b0 ||
            bus.start_recovery !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got phase=%b interval=%0d iv=%b sd=%b sr=%b required all 0",
                     bus.phase, bus.interval, bus.interval_valid,
                     bus.start_drive, bus.start_recovery);
        end
        reset = 1'b1;
        clear_logs();
        period(200);
        period(20);
        checks++;
        if (iv_val.size() != 1 || iv_val[0] != 200 || iv_cyc[0] != rise_q[1] + 5) begin
            errors++;
            $display("FAIL mid_priming: got %0d intervals required 1 of 200 at %0d",
                     iv_val.size(), rise_q[1] + 5);
        end
        checks++;
        if (sd_q.size() != 0 || bus.phase !== 2'b00) begin
            errors++;
            $display("FAIL mid_no_drive: got %0d pulses phase %b required 0/00",
                     sd_q.size(), bus.phase);
        end
    endtask

    initial begin
        bus.sensor = 1'b0;
        test_reset();
        test_drive_recovery();
        test_glitch();
        test_equal_tick_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stroke_detector.md
STROKE_DETECTOR -- requirements
Module: stroke_detector

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable synchronized samples required to accept a sensor level change.
REQ-002 Parameter MIN_TICKS, default 3: consecutive same-sense interval comparisons required to change phase.
REQ-003 Parameter STALL, default 32'd50_000_000: clock cycles without a tick before the block declares the flywheel stopped.
REQ-004 clk  input  1  single clock for the whole block; all state on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-006 sensor  input  1  raw flywheel magnet pulse, asynchronous to clk, may bounce.
REQ-007 start_drive  output  1  one-cycle pulse marking entry into the drive phase.
REQ-008 start_recovery  output  1  one-cycle pulse marking entry into the recovery phase.
REQ-009 phase  output  2  current state: 00 IDLE, 01 RECOVERY, 10 DRIVE.
REQ-010 interval  output  32  clk cycles between the last two accepted ticks.
REQ-011 interval_valid  output  1  one-cycle pulse when interval is updated.

Function
REQ-012 sensor SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Debounced level db SHALL take the synchronized value only after that value has differed from db for DEBOUNCE consecutive cycles; any mismatch-free cycle clears the stability count.
REQ-014 A tick SHALL be a one-cycle internal strobe in the cycle db goes 0->1; latency from a clean sensor rising edge to tick SHALL be 2+DEBOUNCE cycles.
REQ-015 A 32-bit cycle counter SHALL increment every cycle, saturate at 32'hFFFF_FFFF, and on a tick load 1.
REQ-016 On a tick, counter value SHALL be copied into interval and interval_valid pulsed in the following cycle, except on the first tick after reset or after IDLE entry (priming tick: no interval output, no comparison).
REQ-017 Each non-priming tick SHALL compare the new interval with the previous one: smaller = accel, larger = decel, equal = no change to either streak.
REQ-018 accel SHALL increment the accel streak and clear the decel streak; decel SHALL do the opposite; streaks saturate at MIN_TICKS.
REQ-019 IDLE or RECOVERY -> DRIVE when the accel streak reaches MIN_TICKS; start_drive SHALL pulse in the same cycle phase becomes 10; both streaks clear.
REQ-020 DRIVE -> RECOVERY when the decel streak reaches MIN_TICKS; start_recovery SHALL pulse in the same cycle phase becomes 01; both streaks clear.
REQ-021 Phase change SHALL occur 1 cycle after the deciding tick (the interval_valid cycle).
REQ-022 Counter reaching STALL with no tick SHALL force IDLE, clear streaks and previous interval; no start pulse SHALL be emitted; next tick is priming.
REQ-023 IDLE -> RECOVERY SHALL never occur directly; decel streaks in IDLE are ignored.
REQ-024 start_drive and start_recovery SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-025 A tick coinciding with the STALL cycle SHALL be treated as a tick (tick wins; no IDLE entry).

Reset
REQ-026 While reset is low at a clk edge: phase=00, start_drive=0, start_recovery=0, interval=0, interval_valid=0, synchronizer, db, streaks and counter cleared.
REQ-027 Reset asserted mid-stroke SHALL abort any pending transition; the first tick after release is priming.

Verification (DEBOUNCE=2, MIN_TICKS=3, STALL=1000)
REQ-028 Clean pulses with periods 400,300,250,200 cycles after reset -> priming on first tick, interval_valid x3 with interval 300,250,200, then start_drive one cycle after the fourth tick, phase=10.
REQ-029 From DRIVE, periods 220,260,300 -> start_recovery one cycle after third tick, phase=01; a fourth period of 300 (equal) -> no pulse, streaks unchanged.
REQ-030 Sensor glitches of 1 cycle high between real edges -> no extra ticks, interval values unaffected.
REQ-031 Periods 400,300,300,250,200 -> equal comparison skipped, start_drive after the 200-cycle tick (three accels total).
REQ-032 In DRIVE, no edge for 1000 cycles -> phase=00 with no start pulse; next edge is priming (no interval_valid).
REQ-033 reset low for one cycle between the second and third accelerating ticks -> all outputs zero, no start_drive from pre-reset history.
